pirdsp_split_mac_pipe: RTL
==========================

// Module: pirdsp_split_mac_pipe
// PURPOSE
//  Parametrised, pipelined, precision-splittable multiply-accumulate for PIRDSP-style DSP tiles.
//  - FULL mode: one W x W product.
//  - HALF mode: two lane-isolated products, LO_W x LO_W and (W-LO_W) x (W-LO_W).
//  - Each lane has an accumulator with guard bits.
//  - Valid/ready stream interface; global-stall pipeline of PIPE_STAGES registers.
// PARAMETERS
//  W            9   operand width (>=4)
//  LO_W         4   low-lane width in HALF mode; high lane HI_W = W-LO_W
//  PIPE_STAGES  2   product latency in cycles (>=1)
//  G            4   accumulator guard bits per lane
// PORTS
//  clk         in   1         clock
//  reset       in   1         synchronous, active-high
//  in_valid    in   1         input beat valid
//  in_ready    out  1         input beat accepted when in_valid & in_ready
//  a, b        in   W         operands; HALF: lo lane [LO_W-1:0], hi lane [W-1:LO_W]
//  a_sign      in   1         a is two's complement (applies per lane in HALF)
//  b_sign      in   1         b is two's complement (applies per lane in HALF)
//  half        in   1         0 = FULL, 1 = HALF
//  acc_en      in   1         beat updates accumulator
//  acc_clr     in   1         with acc_en: load product instead of adding; clears acc_ovf
//  out_valid   out  1         output beat valid
//  out_ready   in   1         downstream accepts
//  p           out  2W        FULL: product; HALF: {hi[2HI_W-1:0], lo[2LO_W-1:0]}
//  acc         out  2W+2G     FULL: whole word; HALF: hi lane at [2W+2G-1:2LO_W+G], lo at [2LO_W+G-1:0]
//  acc_ovf     out  2         sticky overflow; [0] lo/FULL, [1] hi lane
// BEHAVIOUR
//  - Reset: all stage valids 0, out_valid=0, p=0, acc=0, acc_ovf=0; beats in flight are discarded.
//  - Advance = ~out_valid | out_ready; in_ready = advance (combinational).
//    - The whole pipe shifts on advance; bubbles are not collapsed.
//  - Latency: a beat accepted in cycle t gives out_valid in cycle t+PIPE_STAGES if there is no stall.
//    - Order is strict FIFO; no beat is lost or duplicated.
//    - p, acc and acc_ovf are stable while out_valid & ~out_ready.
//  - Sign extension: product operand MSB is sign-extended only when its *_sign is 1.
//    - HALF: the lo lane sign bit is LO_W-1; the hi lane sign bit is W-1.
//  - HALF lanes are fully isolated: no carry or sign crosses the LO_W / 2LO_W boundary in p or acc.
//  - half, sign bits, acc_en and acc_clr travel with the beat; mode may change every beat.
//  - Accumulator updates when the beat enters the output register:
//    - acc_en=0: acc holds.
//    - acc_en=1, acc_clr=1: acc = sign-extended product.
//    - acc_en=1, acc_clr=0: acc += product.
//  - Mode change (half differs from the last accumulating beat) forces a load as if acc_clr=1.
//  - acc_ovf[i] sets when the true lane sum leaves the lane range.
//    - Range is signed if a_sign|b_sign, else unsigned.
//    - Cleared only by reset or by acc_clr.
// CONFIGURATION
//  - PIRDSP_ACC_SAT_EN defined: overflowing lane clamps to its range limit.
//    - Signed: max/min. Unsigned: all-ones.
//  - Undefined: lane wraps modulo its width. acc_ovf behaves identically in both builds.
// TESTING (W=9, LO_W=4, PIPE_STAGES=2, G=4)
//  1. FULL, signed, a=9'h1FF, b=9'h002 -> two cycles later out_valid=1, p=18'h3FFFE.
//  2. HALF, unsigned, a=b={5'd31,4'd15} -> p[7:0]=8'd225, p[17:8]=10'd961.
//  3. HALF, signed, a={5'h10,4'hF}, b={5'h01,4'h3} -> p[7:0]=8'hFD, p[17:8]=10'h3F0; no cross-lane leak.
//  4. Three back-to-back beats with out_ready=0 for 5 cycles -> in_ready=0 once output is held.
//     - On release: the 3 results emerge in order, with no loss or duplication.
//  5. FULL, unsigned, acc_en, first beat acc_clr, 300 beats of 511*511 -> acc_ovf[0]=1.
//     - Without macro: acc=26'd11227436.
//     - With PIRDSP_ACC_SAT_EN: acc=26'h3FFFFFF.
//  6. Reset asserted with 2 beats in flight and acc non-zero -> next cycle out_valid=0, acc=0, acc_ovf=0.
//     - No stale beat ever appears afterwards.

Source files
------------

// File: rtl/pirdsp_split_mac_pipe.sv
// Pipelined multiply-accumulate that runs as one W x W product (FULL) or two lane-isolated products (HALF).
// Define PIRDSP_ACC_SAT_EN to clamp overflowing accumulator lanes; otherwise lanes wrap.
module pirdsp_split_mac_pipe #(
    parameter int W           = 9,
    parameter int LO_W        = 4,
    parameter int PIPE_STAGES = 2,
    parameter int G           = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    input  logic                 a_sign,
    input  logic                 b_sign,
    input  logic                 half,
    input  logic                 acc_en,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*W-1:0]       p,
    output logic [2*W+2*G-1:0]   acc,
    output logic [1:0]           acc_ovf
);

    localparam int HI_W   = W - LO_W;
    localparam int P_W    = 2 * W;
    localparam int ACC_W  = 2 * W + 2 * G;
    localparam int LO_ACC = 2 * LO_W + G;
    localparam int HI_ACC = 2 * HI_W + G;
    localparam int EXT_W  = ACC_W + 2;

    typedef struct packed {
        logic           valid;
        logic           half;
        logic           sgn;
        logic           acc_en;
        logic           acc_clr;
        logic [P_W-1:0] p;
    } beat_t;

    typedef struct packed {
        logic [ACC_W-1:0] val;
        logic             ovf;
    } lane_t;

    // Sign- or zero-extend the low len bits of v to the full accumulator width.
    function automatic logic [ACC_W-1:0] ext_prod(input logic [ACC_W-1:0] v, input int len,
                                                  input logic sgn);
        logic [ACC_W-1:0] m;
        m = (ACC_W'(1) << len) - ACC_W'(1);
        if (sgn && v[len-1]) return v | ~m;
        return v & m;
    endfunction

    // One accumulator lane of width len; two spare bits hold the true sum for the range check.
    function automatic lane_t lane_update(input logic [ACC_W-1:0] old, input logic [ACC_W-1:0] prod,
                                          input int len, input logic sgn, input logic load);
        logic [EXT_W-1:0] mask, half_mask, old_x, prod_x, sum;
        logic             fits;
        lane_t            r;
        mask      = (EXT_W'(1) << len) - EXT_W'(1);
        half_mask = mask >> 1;
        old_x     = {2'b00, old} & mask;
        if (sgn && old[len-1]) old_x = old_x | ~mask;
        prod_x = {{2{prod[ACC_W-1]}}, prod};
        sum    = load ? prod_x : old_x + prod_x;
        if (sgn) fits = ((sum & ~half_mask) == '0) || ((sum | half_mask) == '1);
        else     fits = (sum & ~mask) == '0;
        r.ovf = ~fits;
        r.val = sum[ACC_W-1:0] & mask[ACC_W-1:0];
`ifdef PIRDSP_ACC_SAT_EN
        if (!fits) begin
            if (!sgn)               r.val = mask[ACC_W-1:0];
            else if (sum[EXT_W-1])  r.val = ~half_mask[ACC_W-1:0] & mask[ACC_W-1:0];
            else                    r.val = half_mask[ACC_W-1:0];
        end
`endif
        return r;
    endfunction

    logic  advance;
    logic  last_half;
    beat_t in_beat;
    beat_t head;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Operands widened by one bit so one signed multiplier covers every signedness mix.
    logic signed [P_W-1:0]      prod_full;
    logic signed [2*LO_W-1:0]   prod_lo;
    logic signed [2*HI_W-1:0]   prod_hi;

    assign prod_full = $signed({a_sign & a[W-1], a}) * $signed({b_sign & b[W-1], b});
    assign prod_lo   = $signed({a_sign & a[LO_W-1], a[LO_W-1:0]})
                     * $signed({b_sign & b[LO_W-1], b[LO_W-1:0]});
    assign prod_hi   = $signed({a_sign & a[W-1], a[W-1:LO_W]})
                     * $signed({b_sign & b[W-1], b[W-1:LO_W]});

    always_comb begin
        in_beat.valid   = in_valid;
        in_beat.half    = half;
        in_beat.sgn     = a_sign | b_sign;
        in_beat.acc_en  = acc_en;
        in_beat.acc_clr = acc_clr;
        in_beat.p       = half ? {prod_hi, prod_lo} : prod_full;
    end

    if (PIPE_STAGES == 1) begin : g_no_stage
        assign head = in_beat;
    end else begin : g_stages
        beat_t stage_q [PIPE_STAGES-1];

        // NOTE: only the valid bits need reset; payload behind a cleared valid is never observed.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k < PIPE_STAGES - 1; k++) stage_q[k].valid <= 1'b0;
            end else if (advance) begin
                stage_q[0] <= in_beat;
                for (int k = 1; k < PIPE_STAGES - 1; k++) stage_q[k] <= stage_q[k-1];
            end
        end

        assign head = stage_q[PIPE_STAGES-2];
    end

    logic             load;
    lane_t            full_r, lo_r, hi_r;
    logic [1:0]       ovf_base, ovf_d;
    logic [ACC_W-1:0] acc_d;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        load     = head.acc_clr | (head.half != last_half);
        full_r   = lane_update(acc, ext_prod({{(ACC_W-P_W){1'b0}}, head.p}, P_W, head.sgn),
                               ACC_W, head.sgn, load);
        lo_r     = lane_update({{(ACC_W-LO_ACC){1'b0}}, acc[LO_ACC-1:0]},
                               ext_prod({{(ACC_W-2*LO_W){1'b0}}, head.p[2*LO_W-1:0]}, 2*LO_W, head.sgn),
                               LO_ACC, head.sgn, load);
        hi_r     = lane_update({{LO_ACC{1'b0}}, acc[ACC_W-1:LO_ACC]},
                               ext_prod({{(ACC_W-2*HI_W){1'b0}}, head.p[P_W-1:2*LO_W]}, 2*HI_W, head.sgn),
                               HI_ACC, head.sgn, load);
        ovf_base = load ? 2'b00 : acc_ovf;
        if (head.half) begin
            acc_d = lo_r.val | (hi_r.val << LO_ACC);
            ovf_d = ovf_base | {hi_r.ovf, lo_r.ovf};
        end else begin
            acc_d = full_r.val;
            ovf_d = ovf_base | {1'b0, full_r.ovf};
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            p         <= '0;
            acc       <= '0;
            acc_ovf   <= '0;
            last_half <= 1'b0;
        end else if (advance) begin
            out_valid <= head.valid;
            if (head.valid) begin
                p <= head.p;
                if (head.acc_en) begin
                    acc       <= acc_d;
                    acc_ovf   <= ovf_d;
                    last_half <= head.half;
                end
            end
        end
    end

endmodule
